sha512_msg_padder: RTL
======================

Name: sha512_msg_padder

Overview:
- Producer side of the SHA-512 chunk interface. Accepts a message as a byte stream, applies FIPS 180-4 SHA-512 padding (0x80, zero fill, 128-bit big-endian bit length), and emits 1024-bit chunks to the chunk compression core.
- Sits between the host byte source and the chunk compressor.
- Flags first and last chunk so downstream logic can load the initial H values and report the digest.

Parameters:
- CNT_W, 64, width of the internal message byte counter. The length field is {zero-extend, count<<3} truncated to 128 bits; counter wraps mod 2^CNT_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  8  message byte
- in_valid  in  1  in_data valid
- in_last  in  1  marks final byte of message (qualified by in_valid)
- in_empty  in  1  with in_valid&in_last: beat carries no byte (zero-length message or no trailing byte)
- in_ready  out  1  byte accepted when in_valid&in_ready
- chunk  out  1024  padded chunk; byte k at bits [1023-8k -: 8] (big-endian, byte 0 MSB)
- chunk_valid  out  1  chunk valid
- chunk_ready  in  1  chunk consumed when chunk_valid&chunk_ready
- chunk_first  out  1  chunk is first of message
- chunk_last  out  1  chunk is final (contains length field)

Behaviour:
- Reset: in_ready=0 during reset, chunk_valid=0, chunk=0, chunk_first=0, chunk_last=0, idx=0, byte count=0, state=FILL, first_pend=1.
- State FILL: in_ready=1. On accept (not in_empty): write byte at index idx, idx++, count++.
  - Non-last byte, idx reaches 128: -> EMIT with chunk_last=0.
  - Last beat: -> PAD.
  - Accept of the 128th byte transitions next cycle; chunk_valid rises 1 cycle after the accept.
- State PAD (1 cycle, in_ready=0), n = idx after the last accept:
  - n<=111: byte n=0x80; bytes n+1..111=0; bytes 112..127 = length. -> EMIT, chunk_last=1.
  - 112<=n<=127: byte n=0x80, rest 0. -> EMIT, chunk_last=0, extra_pend=1, extra_has80=0.
  - n==128: -> EMIT, chunk_last=0, extra_pend=1, extra_has80=1.
- State EMIT: chunk_valid=1, in_ready=0. chunk, chunk_first and chunk_last are held stable until handshake. On chunk_valid&chunk_ready, the next cycle:
  - chunk_valid=0, first_pend=0, idx=0.
  - If extra_pend: -> EXTRA.
  - Else if the emitted chunk was last: count=0, first_pend=1, -> FILL.
  - Otherwise -> FILL.
- State EXTRA (1 cycle): chunk = zeros, byte 0=0x80 if extra_has80, bytes 112..127 = length. extra_pend=0. -> EMIT, chunk_last=1.
- chunk_first equals first_pend latched when entering EMIT.
- Length field = count*8 as 128-bit big-endian, from the count at the last accept.
- Zero-length message (in_empty at idx=0, count=0) produces one chunk: 0x80, zeros, length 0, first=last=1.
- in_empty beat at idx>0 ends the message without adding a byte.
- in_last without in_valid is ignored.
- Throughput: one byte per cycle in FILL. No byte is accepted while in PAD, EMIT or EXTRA.
- Reset mid-operation: discard partial chunk and pending state, return to reset values the next cycle. A chunk in EMIT is withdrawn.
- chunk_ready ignored when chunk_valid=0.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63), chunk_ready=1 -> one chunk: bytes 0..3 = 61 62 63 80, bytes 4..126 = 0, byte 127 = 0x18, first=1, last=1; chunk_valid rises 2 cycles after the last accept.
- 112-byte message of 0xAA -> chunk 1 has bytes 0..111 = AA, byte 112 = 80, rest 0, first=1, last=0. Chunk 2 has bytes 0..125 = 0, bytes 126..127 = 0x0380, first=0, last=1.
- 128-byte message -> chunk 1 = 128 data bytes, last=0. Chunk 2 has byte 0 = 80, byte 126 = 0x04, byte 127 = 0x00, last=1. 111-byte message -> single chunk with byte 111 = 80, length bytes = 0x0378.
- Zero-length (in_valid, in_last, in_empty at start) -> single chunk 0x80 followed by zeros, length 0, first=last=1.
- Backpressure: chunk_ready held low 5 cycles during EMIT -> chunk and flags stable, in_ready=0, source bytes stall. Then a second message after the first is emitted -> chunk_first=1, length counts only the new message.
- Assert reset after 50 bytes accepted -> chunk_valid=0, in_ready=0 during reset. Then "abc" -> output identical to the first scenario.

Source files
------------

// File: rtl/sha512_msg_padder.sv
// SHA-512 message padder: packs a byte stream into 1024-bit chunks, appending
// the 0x80 marker, zero fill and the 128-bit big-endian message bit length.
module sha512_msg_padder #(
  parameter int unsigned CNT_W = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic          in_empty,
  output logic          in_ready,
  output logic [1023:0] chunk,
  output logic          chunk_valid,
  input  logic          chunk_ready,
  output logic          chunk_first,
  output logic          chunk_last
);

  localparam int unsigned CHUNK_BYTES = 128;
  localparam int unsigned LEN_POS     = 112;
  localparam int unsigned IDX_W       = 8;
  localparam int unsigned LEN_W       = 128;

  typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT, S_EXTRA} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [CNT_W-1:0]  count, count_n;
  logic              first_pend, first_pend_n;
  logic              extra_pend, extra_pend_n;
  logic              extra_has80, extra_has80_n;
  logic [1023:0]     chunk_n;
  logic              chunk_valid_n, chunk_first_n, chunk_last_n, in_ready_n;
  logic [LEN_W-1:0]  len_bits;

  // Message length in bits, wrapped to the 128-bit length field.
  assign len_bits = LEN_W'(count) << 3;

  // Next-state and next-output logic; the chunk register doubles as the
  // fill buffer and is cleared after every handshake so padding only has to
  // place the marker and the length.
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    count_n       = count;
    first_pend_n  = first_pend;
    extra_pend_n  = extra_pend;
    extra_has80_n = extra_has80;
    chunk_n       = chunk;
    chunk_valid_n = chunk_valid;
    chunk_first_n = chunk_first;
    chunk_last_n  = chunk_last;

    case (state)
      S_FILL: begin
        if (in_valid && in_ready) begin
          if (!(in_last && in_empty)) begin
            for (int k = 0; k < int'(CHUNK_BYTES); k++) begin
              if (IDX_W'(k) == idx) chunk_n[1023-8*k -: 8] = in_data;
            end
            idx_n   = idx + IDX_W'(1);
            count_n = count + CNT_W'(1);
          end
          if (in_last) begin
            state_n = S_PAD;
          end else if (idx == IDX_W'(CHUNK_BYTES - 1)) begin
            state_n       = S_EMIT;
            chunk_valid_n = 1'b1;
            chunk_first_n = first_pend;
            chunk_last_n  = 1'b0;
          end
        end
      end

      S_PAD: begin
        // idx == 128 matches no byte: the marker moves to the extra chunk.
        for (int k = 0; k < int'(CHUNK_BYTES); k++) begin
          if (IDX_W'(k) == idx) chunk_n[1023-8*k -: 8] = 8'h80;
        end
        if (idx <= IDX_W'(LEN_POS - 1)) begin
          chunk_n[LEN_W-1:0] = len_bits;
          chunk_last_n       = 1'b1;
        end else begin
          extra_pend_n  = 1'b1;
          extra_has80_n = (idx == IDX_W'(CHUNK_BYTES));
          chunk_last_n  = 1'b0;
        end
        state_n       = S_EMIT;
        chunk_valid_n = 1'b1;
        chunk_first_n = first_pend;
      end

      S_EMIT: begin
        if (chunk_ready) begin
          chunk_valid_n = 1'b0;
          first_pend_n  = 1'b0;
          idx_n         = '0;
          chunk_n       = '0;
          if (extra_pend) begin
            state_n = S_EXTRA;
          end else begin
            state_n = S_FILL;
            if (chunk_last) begin
              count_n      = '0;
              first_pend_n = 1'b1;
            end
          end
        end
      end

      S_EXTRA: begin
        chunk_n            = '0;
        chunk_n[1023 -: 8] = extra_has80 ? 8'h80 : 8'h00;
        chunk_n[LEN_W-1:0] = len_bits;
        extra_pend_n       = 1'b0;
        extra_has80_n      = 1'b0;
        state_n            = S_EMIT;
        chunk_valid_n      = 1'b1;
        chunk_first_n      = first_pend;
        chunk_last_n       = 1'b1;
      end

      default: state_n = S_FILL;
    endcase

    in_ready_n = (state_n == S_FILL);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FILL;
      idx         <= '0;
      count       <= '0;
      first_pend  <= 1'b1;
      extra_pend  <= 1'b0;
      extra_has80 <= 1'b0;
      chunk       <= '0;
      chunk_valid <= 1'b0;
      chunk_first <= 1'b0;
      chunk_last  <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      count       <= count_n;
      first_pend  <= first_pend_n;
      extra_pend  <= extra_pend_n;
      extra_has80 <= extra_has80_n;
      chunk       <= chunk_n;
      chunk_valid <= chunk_valid_n;
      chunk_first <= chunk_first_n;
      chunk_last  <= chunk_last_n;
      in_ready    <= in_ready_n;
    end
  end

endmodule
